scan_shift_ctrl: RTL

Serial load/unload controller that sits directly upstream of a shift chain built from the library `dff` cell. It accepts a parallel word over a valid/ready handshake and shifts it MSB-first into the chain. At the same time it captures the bits leaving the chain's last stage and returns the previous chain contents as a parallel word over a second valid/ready handshake. The netlist team uses it to load and read back gate-level register chains without per-bit wiring.

---
 rtl/scan_shift_ctrl.sv | 85 ++++++++
 1 files changed

// File: rtl/scan_shift_ctrl.sv
// scan_shift_ctrl: parallel-to-serial loader for a dff shift chain
// that reads back the previous chain contents as a parallel word.
module scan_shift_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RSTN,
  input  logic [WIDTH-1:0] IN_DATA,
  input  logic             IN_VALID,
  output logic             IN_READY,
  output logic             SER_D,
  output logic             SER_EN,
  input  logic             SER_Q,
  output logic [WIDTH-1:0] OUT_DATA,
  output logic             OUT_VALID,
  input  logic             OUT_READY
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] load_q, load_d;
  logic [WIDTH-1:0] cap_q, cap_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q <= IDLE;
      load_q  <= '0;
      cap_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      load_q  <= load_d;
      cap_q   <= cap_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    load_d  = load_q;
    cap_d   = cap_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (IN_VALID) begin
          load_d  = IN_DATA;
          cap_d   = '0;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        // SER_Q is sampled before the chain advances on this edge
        load_d = {load_q[WIDTH-2:0], 1'b0};
        cap_d  = {cap_q[WIDTH-2:0], SER_Q};
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (OUT_READY) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign IN_READY  = (state_q == IDLE);
  assign SER_EN    = (state_q == SHIFT);
  assign SER_D     = SER_EN & load_q[WIDTH-1];
  assign OUT_VALID = (state_q == DONE);
  assign OUT_DATA  = OUT_VALID ? cap_q : '0;

endmodule
